// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage request fields and forwarding/stall responses of the hazard controller
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  stall;
  logic [CNT_W-1:0]      stall_count;
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_reg_write, id_mem_read, flush,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_reg_write, id_mem_read, flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding-select and load-use stall controller for a 5-stage MIPS pipeline
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  fwd_hazard_ctrl_if.slave  bus
);
  typedef logic [REG_ADDR_W-1:0] reg_t;
  reg_t             ex_rs_q, ex_rt_q, ex_dest_q, mem_dest_q, wb_dest_q;
  reg_t             ex_rs_d, ex_rt_d, ex_dest_d;
  logic             ex_rw_q, ex_mr_q, mem_rw_q, wb_rw_q;
  logic             ex_rw_d, ex_mr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard, stall, bubble;
  logic [1:0]       sel_a, sel_b;
  always_comb begin
    hazard  = bus.id_valid & ex_mr_q & ex_rw_q & (ex_dest_q != '0) &
              ((ex_dest_q == bus.id_rs) | (bus.id_uses_rt & (ex_dest_q == bus.id_rt)));
    stall   = hazard & ~bus.flush;
    // a flushed or stalled ID instruction never reaches EX
    bubble  = hazard | bus.flush;
    ex_rs_d   = bubble ? '0 : bus.id_rs;
    ex_rt_d   = bubble ? '0 : bus.id_rt;
    ex_dest_d = bubble ? '0 : bus.id_dest;
    ex_rw_d   = ~bubble & bus.id_valid & bus.id_reg_write;
    ex_mr_d   = ~bubble & bus.id_valid & bus.id_mem_read;
    cnt_d     = (stall & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    // EX/MEM checked first so the youngest producer wins; $0 is never forwarded
    sel_a = (mem_rw_q & (mem_dest_q != '0) & (mem_dest_q == ex_rs_q)) ? 2'b01 :
            (wb_rw_q  & (wb_dest_q  != '0) & (wb_dest_q  == ex_rs_q)) ? 2'b10 : 2'b00;
    sel_b = (mem_rw_q & (mem_dest_q != '0) & (mem_dest_q == ex_rt_q)) ? 2'b01 :
            (wb_rw_q  & (wb_dest_q  != '0) & (wb_dest_q  == ex_rt_q)) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_dest_q  <= '0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      mem_dest_q <= '0;
      mem_rw_q   <= 1'b0;
      wb_dest_q  <= '0;
      wb_rw_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_dest_q  <= ex_dest_d;
      ex_rw_q    <= ex_rw_d;
      ex_mr_q    <= ex_mr_d;
      mem_dest_q <= ex_dest_q;
      mem_rw_q   <= ex_rw_q;
      wb_dest_q  <= mem_dest_q;
      wb_rw_q    <= mem_rw_q;
      cnt_q      <= cnt_d;
    end
  end
  assign bus.fwd_a_sel   = sel_a;
  assign bus.fwd_b_sel   = sel_b;
  assign bus.stall       = stall;
  assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed and random checks of two controllers (16-bit and 2-bit stall counters)
module tb_fwd_hazard_ctrl;
  logic       clk, rst_n;
  logic       id_valid, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [4:0] id_rs, id_rt, id_dest;
  int         n_cmp, n_err;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) b0 ();
  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  b1 ();

  assign b0.id_valid = id_valid;     assign b1.id_valid = id_valid;
  assign b0.id_rs = id_rs;           assign b1.id_rs = id_rs;
  assign b0.id_rt = id_rt;           assign b1.id_rt = id_rt;
  assign b0.id_uses_rt = id_uses_rt; assign b1.id_uses_rt = id_uses_rt;
  assign b0.id_dest = id_dest;       assign b1.id_dest = id_dest;
  assign b0.id_reg_write = id_reg_write; assign b1.id_reg_write = id_reg_write;
  assign b0.id_mem_read = id_mem_read;   assign b1.id_mem_read = id_mem_read;
  assign b0.flush = flush;           assign b1.flush = flush;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));
  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2))  u1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB
  typedef struct {
    logic [4:0] rs, rt, dest;
    bit         rw, mr;
  } slot_t;
  slot_t pipe[3];
  int    m_cnt16, m_cnt2;

  function automatic bit m_hazard();
    return id_valid && pipe[0].mr && pipe[0].rw && pipe[0].dest != 0 &&
           (pipe[0].dest == id_rs || (id_uses_rt && pipe[0].dest == id_rt));
  endfunction

  function automatic bit m_stall();
    return m_hazard() && !flush;
  endfunction

  function automatic logic [1:0] m_sel(input logic [4:0] src);
    for (int k = 1; k <= 2; k++)
      if (pipe[k].rw && pipe[k].dest != 0 && pipe[k].dest == src) return 2'(k);
    return 2'd0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  task automatic tick();
    if (m_stall()) begin
      m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
      m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (m_hazard() || flush) pipe[0] = '{default: 0};
    else pipe[0] = '{rs: id_rs, rt: id_rt, dest: id_dest,
                     rw: id_reg_write && id_valid, mr: id_mem_read && id_valid};
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                       input logic [4:0] dest, input bit rw, input bit mr, input bit fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    drive(1, s, t, 1, d, 1, 0, 0);
  endtask

  task automatic lw(input logic [4:0] d, input logic [4:0] base);
    drive(1, base, d, 0, d, 1, 1, 0);
  endtask

  task automatic nops(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 5'd7, 5'd7, 1, 5'd7, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    m_reset();
    n_cmp++;
    if ({b0.fwd_a_sel, b0.fwd_b_sel, b0.stall} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_sel_stall got=%b exp=00000", {b0.fwd_a_sel, b0.fwd_b_sel, b0.stall});
    end
    n_cmp++;
    if (b0.stall_count !== 16'd0 || b1.stall_count !== 2'd0) begin
      n_err++;
      $display("FAIL reset_count got=%0d/%0d exp=0/0", b0.stall_count, b1.stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nops(3);
  endtask

  task automatic test_alu_fwd();
    alu(3, 1, 2);
    tick();
    alu(5, 3, 3);
    @(negedge clk);
    n_cmp++;
    if (b0.stall !== 1'b0) begin
      n_err++;
      $display("FAIL alu_fwd_nostall got=%b exp=0", b0.stall);
    end
    tick();
    nops(0);
    @(negedge clk);
    n_cmp++;
    if ({b0.fwd_a_sel, b0.fwd_b_sel, b0.stall} !== 5'b01010) begin
      n_err++;
      $display("FAIL alu_fwd_sel got=%b exp=01010", {b0.fwd_a_sel, b0.fwd_b_sel, b0.stall});
    end
    nops(3);
  endtask

  task automatic test_dist2();
    alu(4, 1, 2); tick();
    alu(4, 3, 3); tick();
    alu(6, 4, 2); tick();
    nops(0);
    @(negedge clk);
    n_cmp++;
    if ({b0.fwd_a_sel, b0.fwd_b_sel} !== 4'b0100) begin
      n_err++;
      $display("FAIL dist2_priority got=%b exp=0100", {b0.fwd_a_sel, b0.fwd_b_sel});
    end
    nops(3);
    alu(4, 1, 2); tick();
    nops(1);
    alu(6, 4, 2); tick();
    nops(0);
    @(negedge clk);
    n_cmp++;
    if ({b0.fwd_a_sel, b0.fwd_b_sel} !== 4'b1000) begin
      n_err++;
      $display("FAIL dist2_wb got=%b exp=1000", {b0.fwd_a_sel, b0.fwd_b_sel});
    end
    nops(3);
  endtask

  task automatic test_load_use();
    lw(7, 1); tick();
    alu(8, 7, 1);
    @(negedge clk);
    n_cmp++;
    if (b0.stall !== 1'b1 || b0.stall_count !== 16'd0) begin
      n_err++;
      $display("FAIL lu_stall got=%b/%0d exp=1/0", b0.stall, b0.stall_count);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (b0.stall !== 1'b0 || b0.stall_count !== 16'd1 || b1.stall_count !== 2'd1) begin
      n_err++;
      $display("FAIL lu_bubble got=%b/%0d/%0d exp=0/1/1", b0.stall, b0.stall_count, b1.stall_count);
    end
    tick();
    nops(0);
    @(negedge clk);
    n_cmp++;
    if ({b0.fwd_a_sel, b0.fwd_b_sel, b0.stall} !== 5'b10000 || b0.stall_count !== 16'd1) begin
      n_err++;
      $display("FAIL lu_fwd got=%b/%0d exp=10000/1", {b0.fwd_a_sel, b0.fwd_b_sel, b0.stall}, b0.stall_count);
    end
    nops(3);
    lw(7, 1); tick();
    drive(1, 2, 7, 0, 9, 1, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (b0.stall !== 1'b0) begin
      n_err++;
      $display("FAIL lu_no_rt got=%b exp=0", b0.stall);
    end
    tick();
    nops(3);
  endtask

  task automatic test_zero_flush();
    lw(0, 1); tick();
    alu(8, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (b0.stall !== 1'b0) begin
      n_err++;
      $display("FAIL zero_stall got=%b exp=0", b0.stall);
    end
    tick();
    nops(0);
    @(negedge clk);
    n_cmp++;
    if ({b0.fwd_a_sel, b0.fwd_b_sel} !== 4'b0000) begin
      n_err++;
      $display("FAIL zero_sel got=%b exp=0000", {b0.fwd_a_sel, b0.fwd_b_sel});
    end
    nops(3);
    lw(7, 1); tick();
    drive(1, 7, 1, 1, 8, 1, 0, 1);
    @(negedge clk);
    n_cmp++;
    if (b0.stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stall got=%b exp=0", b0.stall);
    end
    tick();
    alu(10, 8, 8);
    tick();
    nops(0);
    @(negedge clk);
    n_cmp++;
    if ({b0.fwd_a_sel, b0.fwd_b_sel} !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_bubble got=%b exp=0000", {b0.fwd_a_sel, b0.fwd_b_sel});
    end
    nops(3);
  endtask

  task automatic test_saturation_reset();
    repeat (5) begin
      lw(7, 1); tick();
      alu(8, 7, 1); tick(); tick();
      nops(2);
    end
    @(negedge clk);
    n_cmp++;
    if (b1.stall_count !== 2'd3 || b0.stall_count !== 16'(m_cnt16)) begin
      n_err++;
      $display("FAIL sat_count got=%0d/%0d exp=3/%0d", b1.stall_count, b0.stall_count, m_cnt16);
    end
    lw(7, 1); tick();
    alu(8, 7, 1);
    @(negedge clk);
    n_cmp++;
    if (b0.stall !== 1'b1 || b1.stall !== 1'b1) begin
      n_err++;
      $display("FAIL mid_stall_pre got=%b%b exp=11", b0.stall, b1.stall);
    end
    rst_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if (b0.stall !== 1'b0 || b1.stall !== 1'b0 || b0.stall_count !== 16'd0 || b1.stall_count !== 2'd0) begin
      n_err++;
      $display("FAIL mid_stall_reset got=%b%b/%0d/%0d exp=00/0/0", b0.stall, b1.stall, b0.stall_count, b1.stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nops(1);
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    bit         es;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      @(negedge clk);
      ea = m_sel(pipe[0].rs);
      eb = m_sel(pipe[0].rt);
      es = m_stall();
      n_cmp++;
      if ({b0.fwd_a_sel, b0.fwd_b_sel, b0.stall} !== {ea, eb, es} || b0.stall_count !== 16'(m_cnt16)) begin
        n_err++;
        $display("FAIL rand_u0 cyc=%0d got=%b/%0d exp=%b/%0d", i,
                 {b0.fwd_a_sel, b0.fwd_b_sel, b0.stall}, b0.stall_count, {ea, eb, es}, m_cnt16);
      end
      n_cmp++;
      if (b1.stall !== es || b1.stall_count !== 2'(m_cnt2)) begin
        n_err++;
        $display("FAIL rand_u1 cyc=%0d got=%b/%0d exp=%b/%0d", i, b1.stall, b1.stall_count, es, m_cnt2);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_reset();
    test_reset();
    test_alu_fwd();
    test_dist2();
    test_load_use();
    test_zero_flush();
    test_saturation_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline. Tracks destination-register and write-enable state through ID/EX, EX/MEM and MEM/WB shadow registers. Drives the 2-bit select of both EX-stage 32-bit 3:1 operand multiplexers. Raises a one-cycle stall for load-use hazards and counts stall cycles for performance measurement.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width
- CNT_W, 16, stall-counter width

Ports:
- Clk, input, 1, pipeline clock; all state updates on rising edge
- Rst_n, input, 1, asynchronous active-low reset
- id_valid, input, 1, ID stage holds a real instruction
- id_rs, input, REG_ADDR_W, ID source register A
- id_rt, input, REG_ADDR_W, ID source register B
- id_uses_rt, input, 1, the ID instruction reads rt as a source
- id_dest, input, REG_ADDR_W, ID destination register, already resolved between rt and rd
- id_reg_write, input, 1, the ID instruction writes the register file
- id_mem_read, input, 1, the ID instruction is a load
- flush, input, 1, discard the ID instruction, e.g. on a taken branch
- fwd_a_sel, output, 2, select for operand-A mux
- fwd_b_sel, output, 2, select for operand-B mux
- stall, output, 1, hold PC and IF/ID; ID/EX receives a bubble
- stall_count, output, CNT_W, saturating count of stall cycles

## Operation
Select encoding, identical on both muxes:
- 2'b00: register-file value (inA)
- 2'b01: EX/MEM ALU result (inB)
- 2'b10: MEM/WB write-back value (inC)
- 2'b11: never driven

Shadow state:
- ex_rs, ex_rt, ex_dest, ex_rw, ex_mr
- mem_dest, mem_rw
- wb_dest, wb_rw
- All shadow state resets to 0.

Advance, every rising edge:
- wb <= mem, mem <= ex.
- ex <= ID fields, with ex_rw = id_reg_write & id_valid and ex_mr = id_mem_read & id_valid.
- If stall or flush is asserted, ex instead loads a bubble: all ex fields = 0.

Hazard detection:
- hazard = id_valid & ex_mr & ex_rw & (ex_dest != 0) & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)).
- stall = hazard & ~flush. Combinational. If flush and hazard coincide, flush wins: stall = 0 and a bubble enters EX.

Forwarding, combinational from shadow state, shown for operand A (operand B is the same with ex_rt):
- If mem_rw & mem_dest != 0 & mem_dest == ex_rs, select 01.
- Else if wb_rw & wb_dest != 0 & wb_dest == ex_rs, select 10.
- Else select 00.
- EX/MEM has priority over MEM/WB, so the youngest producer wins.
- Register $0 is never forwarded.
- Same-cycle WB-write / ID-read is handled by the register file, not by this block.

stall_count:
- Increments on each rising edge where stall = 1.
- Saturates at all-ones.
- Cleared only by reset.

## Timing
- Reset, asynchronous: all shadow state = 0; fwd_a_sel = fwd_b_sel = 2'b00; stall = 0; stall_count = 0.
- Outputs are valid in the same cycle as the corresponding EX/ID contents, with no added latency; select outputs are combinational from registered state.
- A load-use hazard produces exactly one stall cycle:
  - cycle N: load in EX, dependent instruction in ID, stall = 1
  - cycle N+1: bubble in EX, stall = 0
  - cycle N+2: dependent instruction in EX with select 10
- Back-to-back ALU dependency: select 01 in the consumer's EX cycle, with no stall.
- Reset asserted mid-stall: stall drops immediately and all pending forwarding state is lost.
- The shadow pipeline does not stall internally. The bubble insertion is what keeps it aligned with the datapath.

## Test plan
- Reset check: hold Rst_n = 0 with arbitrary inputs -> fwd_a_sel = fwd_b_sel = 00, stall = 0, stall_count = 0.
- ALU-to-ALU forward: add $3 then sub $5,$3,$3 -> in sub's EX cycle fwd_a_sel = fwd_b_sel = 01, stall never asserted.
- Distance-2 forward with priority: add $4 / or $4 / and $6,$4,$2 -> and sees fwd_a_sel = 01 (younger producer), fwd_b_sel = 00; remove the middle producer -> fwd_a_sel = 10.
- Load-use: lw $7 then add $8,$7,$1 -> stall = 1 for exactly one cycle, stall_count 0 -> 1, add's EX cycle fwd_a_sel = 10; repeat with id_uses_rt = 0 and rt = $7 -> no stall.
- $0 and flush: lw $0 followed by a $0 consumer -> no stall and select 00; lw $7 + dependent instruction with flush = 1 in the same cycle -> stall = 0 and a bubble enters EX.
- Counter saturation: CNT_W = 2, force 5 load-use stalls -> stall_count stops at 3; assert Rst_n = 0 mid-stall -> stall and stall_count go to 0 at once.
